// File: rtl/stack_arbiter_if.sv
// ----------------------------------------------------------------------------
// stack_arbiter_if
// Requester-side bundle of the two-client stack arbiter.
//   req_valid[1:0]  request valid per requester, held until its req_ready
//   req_op[1:0]     0 = push, 1 = pop (per requester)
//   req_data        push data, bits [DW-1:0] belong to requester 0
//   req_ready[1:0]  one-cycle pulse: request accepted
//   rsp_valid[1:0]  one-cycle pulse: transaction complete
//   rsp_data        popped value (0 for push), valid with rsp_valid
//   rsp_err         overflow / underflow / stack error, valid with rsp_valid
// Modports: master = client side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface stack_arbiter_if #(
  parameter int DW = 8
);
  logic [1:0]      req_valid;
  logic [1:0]      req_op;
  logic [2*DW-1:0] req_data;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_arbiter.sv
// ----------------------------------------------------------------------------
// stack_arbiter
// Shares one stack between two requesters. Picks a winner, rejects pushes on a
// full stack and pops on an empty one without touching the stack, otherwise
// issues a single-cycle push/pop strobe, waits POP_LAT cycles and responds.
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        stack_arbiter_if.slave requester handshake
//   stk_push   stack push strobe
//   stk_pop    stack pop strobe
//   stk_din    stack data_in
//   stk_dout   stack data_out (valid POP_LAT cycles after stk_pop)
//   stk_error  stack error flag, folded into rsp_err
//   level      current occupancy
//
// Configuration macro: STACK_ARB_FIXED_PRI_EN
//   defined   -> requester 0 always wins a simultaneous request
//   undefined -> round-robin (requester not granted last wins)
// ----------------------------------------------------------------------------
module stack_arbiter #(
  parameter int DEPTH   = 16,
  parameter int DW      = 8,
  parameter int POP_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  stack_arbiter_if.slave             bus,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [DW-1:0]              stk_din,
  input  logic [DW-1:0]              stk_dout,
  input  logic                       stk_error,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = (POP_LAT > 1) ? $clog2(POP_LAT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]    state_reg;
  logic          winner_reg;
  logic          op_reg;
  logic          rej_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    req_ready_reg;
  logic [1:0]    rsp_valid_reg;
  logic [DW-1:0] rsp_data_reg;
  logic          rsp_err_reg;
  logic          stk_push_reg;
  logic          stk_pop_reg;
  logic [DW-1:0] stk_din_reg;
  logic [LW-1:0] level_reg;
`ifndef STACK_ARB_FIXED_PRI_EN
  logic          last_grant_reg;
`endif

  logic          any_valid;
  logic          win;
  logic          win_op;
  logic [DW-1:0] win_data;
  logic          reject;

  assign any_valid = |bus.req_valid;

  always_comb begin
`ifdef STACK_ARB_FIXED_PRI_EN
    win = ~bus.req_valid[0];
`else
    // Both valid: the requester not granted last time wins.
    if (&bus.req_valid) win = ~last_grant_reg;
    else                win = ~bus.req_valid[0];
`endif
    win_op   = win ? bus.req_op[1] : bus.req_op[0];
    win_data = win ? bus.req_data[2*DW-1:DW] : bus.req_data[DW-1:0];
    // Saturated requests never reach the stack, so level cannot wrap.
    reject   = win_op ? (level_reg == '0) : (level_reg == LW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      winner_reg     <= 1'b0;
      op_reg         <= 1'b0;
      rej_reg        <= 1'b0;
      cnt_reg        <= '0;
      req_ready_reg  <= '0;
      rsp_valid_reg  <= '0;
      rsp_data_reg   <= '0;
      rsp_err_reg    <= 1'b0;
      stk_push_reg   <= 1'b0;
      stk_pop_reg    <= 1'b0;
      stk_din_reg    <= '0;
      level_reg      <= '0;
`ifndef STACK_ARB_FIXED_PRI_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      // Pulsed outputs default low; states below raise them for one cycle.
      req_ready_reg <= '0;
      rsp_valid_reg <= '0;
      stk_push_reg  <= 1'b0;
      stk_pop_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          rsp_data_reg <= '0;
          rsp_err_reg  <= 1'b0;
          if (any_valid) begin
            winner_reg    <= win;
            op_reg        <= win_op;
            req_ready_reg <= win ? 2'b10 : 2'b01;
`ifndef STACK_ARB_FIXED_PRI_EN
            last_grant_reg <= win;
`endif
            if (reject) begin
              rej_reg   <= 1'b1;
              state_reg <= ST_RESP;
            end else begin
              // Strobes and level are registered so they appear with req_ready.
              rej_reg      <= 1'b0;
              stk_push_reg <= ~win_op;
              stk_pop_reg  <= win_op;
              stk_din_reg  <= win_data;
              level_reg    <= win_op ? (level_reg - LW'(1)) : (level_reg + LW'(1));
              state_reg    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt_reg   <= CW'(POP_LAT - 1);
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            // Last wait cycle: pop data is valid on stk_dout now.
            rsp_valid_reg <= winner_reg ? 2'b10 : 2'b01;
            rsp_data_reg  <= op_reg ? stk_dout : '0;
            rsp_err_reg   <= stk_error;
            state_reg     <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          // Accepted transactions show rsp_valid during RESP; rejected ones
          // used RESP to show req_ready and respond in the following cycle.
          state_reg <= ST_IDLE;
          if (rej_reg) begin
            rsp_valid_reg <= winner_reg ? 2'b10 : 2'b01;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b1;
          end else begin
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign stk_push      = stk_push_reg;
  assign stk_pop       = stk_pop_reg;
  assign stk_din       = stk_din_reg;
  assign level         = level_reg;

endmodule
